// File: rtl/tlb_repl_ctrl.sv
// Replacement/refill controller for the 8-way fully-associative TLB:
// tree-PLRU state, victim choice, PTW sequencing, refill write and per-way valid bits.
module tlb_repl_ctrl #(
    parameter int VPN_W = 27,
    parameter int NWAYS = 8     // fixed at 8: the PLRU tree below is hard-wired to 3 levels
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hit_valid,
    input  logic [NWAYS-1:0] hit_ways,
    input  logic             miss_valid,
    output logic             miss_ready,
    input  logic [VPN_W-1:0] miss_vpn,
    output logic             ptw_req_valid,
    input  logic             ptw_req_ready,
    output logic [VPN_W-1:0] ptw_req_vpn,
    input  logic             ptw_resp_valid,
    input  logic             ptw_resp_pf,
    output logic             refill_we,
    output logic [2:0]       refill_way,
    output logic [VPN_W-1:0] refill_vpn,
    output logic             miss_done,
    output logic             miss_fault,
    input  logic             sfence,
    output logic [NWAYS-1:0] entry_valid,
    output logic [NWAYS-1:0] plru_state,
    output logic             busy
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]       state;
    logic [VPN_W-1:0] vpn_q;
    logic [2:0]       way_q;
    logic             drop_q;
    logic [2:0]       hit_way, inv_way, plru_way;
    logic             l1, l2;

    // Point every tree node on the path to w away from w.
    function automatic logic [7:0] plru_upd(input logic [7:0] p, input logic [2:0] w);
        logic [7:0] n;
        n = p;
        n[1] = ~w[2];
        n[{2'b01, w[2]}] = ~w[1];
        n[{1'b1, w[2], w[1]}] = ~w[0];
        n[0] = 1'b0;
        return n;
    endfunction

    always_comb begin
        hit_way = '0;
        for (int i = 0; i < NWAYS; i++)
            if (hit_ways[i]) hit_way = hit_way | 3'(i);
    end

    always_comb begin
        inv_way = '0;
        for (int i = NWAYS - 1; i >= 0; i--)
            if (!entry_valid[i]) inv_way = 3'(i);
    end

    assign l1       = plru_state[1];
    assign l2       = plru_state[{2'b01, l1}];
    assign plru_way = {l1, l2, plru_state[{1'b1, l1, l2}]};

    assign miss_ready    = (state == S_IDLE) && !sfence;
    assign ptw_req_valid = (state == S_REQ);
    assign ptw_req_vpn   = vpn_q;
    assign refill_we     = (state == S_COMMIT) && !sfence;
    assign refill_way    = way_q;
    assign refill_vpn    = vpn_q;
    assign busy          = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            vpn_q       <= '0;
            way_q       <= '0;
            drop_q      <= 1'b0;
            miss_done   <= 1'b0;
            miss_fault  <= 1'b0;
            entry_valid <= '0;
            plru_state  <= '0;
        end else begin
            miss_done  <= 1'b0;
            miss_fault <= 1'b0;
            case (state)
                S_IDLE: if (miss_valid && miss_ready) begin
                    vpn_q  <= miss_vpn;
                    way_q  <= (&entry_valid) ? plru_way : inv_way;
                    drop_q <= 1'b0;
                    state  <= S_REQ;
                end
                S_REQ: begin
                    if (sfence) drop_q <= 1'b1;
                    if (ptw_req_ready) state <= S_WAIT;
                end
                S_WAIT: begin
                    if (sfence) drop_q <= 1'b1;
                    // a same-cycle sfence also kills the refill
                    if (ptw_resp_valid) begin
                        if (ptw_resp_pf || drop_q || sfence) begin
                            state      <= S_IDLE;
                            miss_done  <= 1'b1;
                            miss_fault <= ptw_resp_pf;
                        end else begin
                            state <= S_COMMIT;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    miss_done <= 1'b1;
                end
            endcase

            if (sfence) begin
                entry_valid <= '0;
                plru_state  <= '0;
            end else if (state == S_COMMIT) begin
                entry_valid[way_q] <= 1'b1;
                plru_state         <= plru_upd(plru_state, way_q);
            end else if (hit_valid) begin
                plru_state <= plru_upd(plru_state, hit_way);
            end
        end
    end
endmodule

// File: tb/tb_tlb_repl_ctrl.sv
// Directed bench for tlb_repl_ctrl; expected PLRU/valid values are hand-derived from the tree rules.
module tb_tlb_repl_ctrl;
    logic        clk, reset;
    logic        hit_valid;
    logic [7:0]  hit_ways;
    logic        miss_valid, miss_ready;
    logic [26:0] miss_vpn;
    logic        ptw_req_valid, ptw_req_ready;
    logic [26:0] ptw_req_vpn;
    logic        ptw_resp_valid, ptw_resp_pf;
    logic        refill_we;
    logic [2:0]  refill_way;
    logic [26:0] refill_vpn;
    logic        miss_done, miss_fault, sfence;
    logic [7:0]  entry_valid, plru_state;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    tlb_repl_ctrl #(.VPN_W(27), .NWAYS(8)) dut (
        .clk(clk), .reset(reset),
        .hit_valid(hit_valid), .hit_ways(hit_ways),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_vpn(miss_vpn),
        .ptw_req_valid(ptw_req_valid), .ptw_req_ready(ptw_req_ready), .ptw_req_vpn(ptw_req_vpn),
        .ptw_resp_valid(ptw_resp_valid), .ptw_resp_pf(ptw_resp_pf),
        .refill_we(refill_we), .refill_way(refill_way), .refill_vpn(refill_vpn),
        .miss_done(miss_done), .miss_fault(miss_fault),
        .sfence(sfence), .entry_valid(entry_valid), .plru_state(plru_state), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!reset && hit_valid)
            assert ($onehot(hit_ways)) else $error("illegal hit_ways %b", hit_ways);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full miss with minimum latency; pf=1 ends as a fault without a refill.
    task automatic do_miss(input logic [26:0] vpn, input logic [2:0] way, input logic pf);
        miss_valid = 1'b1; miss_vpn = vpn; #1;
        chk("miss_ready", miss_ready, 1);
        tick();
        miss_valid = 1'b0; miss_vpn = ~vpn; ptw_req_ready = 1'b1; #1;
        chk("req_valid", ptw_req_valid, 1);
        chk("req_vpn", ptw_req_vpn, vpn);
        chk("busy", busy, 1);
        tick();
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b1; ptw_resp_pf = pf; #1;
        chk("req_gone", ptw_req_valid, 0);
        chk("no_we_wait", refill_we, 0);
        tick();
        ptw_resp_valid = 1'b0; ptw_resp_pf = 1'b0; #1;
        if (!pf) begin
            chk("refill_we", refill_we, 1);
            chk("refill_way", refill_way, way);
            chk("refill_vpn", refill_vpn, vpn);
            chk("done_early", miss_done, 0);
            tick();
            #1;
        end
        chk("we_off", refill_we, 0);
        chk("miss_done", miss_done, 1);
        chk("miss_fault", miss_fault, pf);
        chk("busy_end", busy, 0);
    endtask

    logic [7:0] fill_plru [8];

    initial begin
        fill_plru = '{8'h16, 8'h06, 8'h22, 8'h02, 8'h48, 8'h08, 8'h80, 8'h00};
        reset = 1'b1; hit_valid = 1'b0; hit_ways = '0; miss_valid = 1'b0; miss_vpn = '0;
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b0; ptw_resp_pf = 1'b0; sfence = 1'b0;
        tick(); tick();
        reset = 1'b0; #1;
        chk("rst_ev", entry_valid, 8'h00);
        chk("rst_plru", plru_state, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_req", ptw_req_valid, 0);
        chk("rst_we", refill_we, 0);
        chk("rst_done", miss_done, 0);
        chk("rst_fault", miss_fault, 0);
        chk("rst_ready", miss_ready, 1);

        // T1: hit updates from a clean tree
        hit_valid = 1'b1; hit_ways = 8'h01; tick();
        chk("t1_hit0", plru_state, 8'h16);
        hit_ways = 8'h80; tick();
        hit_valid = 1'b0; hit_ways = '0;
        chk("t1_hit7", plru_state, 8'h14);

        // Fill: lowest invalid way wins over the PLRU pointer
        for (int k = 0; k < 8; k++) begin
            do_miss(27'h100 + 27'(k), 3'(k), 1'b0);
            chk("fill_ev", entry_valid, (32'h1 << (k + 1)) - 1);
            chk("fill_plru", plru_state, fill_plru[k]);
        end

        // T2: all valid, PLRU victim
        hit_valid = 1'b1; hit_ways = 8'h01; tick();
        hit_valid = 1'b0; hit_ways = '0;
        chk("t2_plru0", plru_state, 8'h16);
        do_miss(27'h123, 3'd4, 1'b0);
        chk("t2_plru", plru_state, 8'h5C);
        chk("t2_ev", entry_valid, 8'hFF);

        // T4: stalled request, hit during REQ, hit in COMMIT discarded
        miss_valid = 1'b1; miss_vpn = 27'h0ABCDEF; #1;
        tick();
        miss_vpn = 27'h1; hit_valid = 1'b1; hit_ways = 8'h80; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_req", ptw_req_valid, 1);
            chk("t4_vpn", ptw_req_vpn, 27'h0ABCDEF);
            chk("t4_ready", miss_ready, 0);
            tick();
            hit_valid = 1'b0; hit_ways = '0;
        end
        miss_valid = 1'b0;
        chk("t4_plru_hit", plru_state, 8'h54);
        ptw_req_ready = 1'b1; tick();
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b1; tick();
        ptw_resp_valid = 1'b0; hit_valid = 1'b1; hit_ways = 8'h01; #1;
        chk("t4_we", refill_we, 1);
        chk("t4_way", refill_way, 3'd2);
        chk("t4_rvpn", refill_vpn, 27'h0ABCDEF);
        tick();
        hit_valid = 1'b0; hit_ways = '0; #1;
        chk("t4_done", miss_done, 1);
        chk("t4_plru", plru_state, 8'h72);

        // T5: page fault
        do_miss(27'h55, 3'd5, 1'b1);
        chk("t5_plru", plru_state, 8'h72);
        chk("t5_ev", entry_valid, 8'hFF);
        tick();
        chk("t5_pulse", miss_done, 0);

        // T6: sfence in WAIT, response two cycles later
        miss_valid = 1'b1; miss_vpn = 27'h77; tick();
        miss_valid = 1'b0; ptw_req_ready = 1'b1; tick();
        ptw_req_ready = 1'b0; sfence = 1'b1; tick();
        sfence = 1'b0; #1;
        chk("t6_ev", entry_valid, 8'h00);
        chk("t6_plru", plru_state, 8'h00);
        chk("t6_busy", busy, 1);
        tick();
        ptw_resp_valid = 1'b1; tick();
        ptw_resp_valid = 1'b0; #1;
        chk("t6_we", refill_we, 0);
        chk("t6_done", miss_done, 1);
        chk("t6_fault", miss_fault, 0);
        chk("t6_ev2", entry_valid, 8'h00);
        chk("t6_idle", busy, 0);

        // sfence in COMMIT suppresses the write
        miss_valid = 1'b1; miss_vpn = 27'h99; tick();
        miss_valid = 1'b0; ptw_req_ready = 1'b1; tick();
        ptw_req_ready = 1'b0; ptw_resp_valid = 1'b1; tick();
        ptw_resp_valid = 1'b0; sfence = 1'b1; #1;
        chk("c_we", refill_we, 0);
        tick();
        sfence = 1'b0; #1;
        chk("c_done", miss_done, 1);
        chk("c_fault", miss_fault, 0);
        chk("c_ev", entry_valid, 8'h00);
        chk("c_plru", plru_state, 8'h00);

        // Reset mid-miss, stray response afterwards is ignored
        do_miss(27'h3, 3'd0, 1'b0);
        chk("r_ev", entry_valid, 8'h01);
        miss_valid = 1'b1; miss_vpn = 27'h44; tick();
        miss_valid = 1'b0; reset = 1'b1; tick();
        reset = 1'b0; #1;
        chk("r_busy", busy, 0);
        chk("r_ev0", entry_valid, 8'h00);
        chk("r_req", ptw_req_valid, 0);
        ptw_resp_valid = 1'b1; tick();
        ptw_resp_valid = 1'b0; #1;
        chk("r_stray_busy", busy, 0);
        chk("r_stray_done", miss_done, 0);
        chk("r_stray_we", refill_we, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
